mdio_arbitro: RTL and testbench
===============================

Name: mdio_arbitro

Overview:
- Two-port round-robin arbiter and sequencer in front of the single MDIO management controller (the block that drives MDIO_OUT/MDIO_OE toward the PHY-side receiver).
- Each host requester submits a 32-bit MDIO frame; the arbiter serialises access, launches one transaction at a time and waits for completion.
- It returns read data and a done pulse to the owner, and aborts hung transactions via a timeout.

Parameters:
- TIMEOUT, 64: max cycles in WAIT before abort (must be ≥ 40, one full frame plus margin).
- CNT_W, 7: width of timeout counter; 2^CNT_W > TIMEOUT.

Ports:
- MDC  input  1  block clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- REQ_A  input  1  requester A transaction request, level; held until DONE_A.
- T_DATA_A  input  32  requester A frame: [31:30] ST, [29:28] OP, [27:23] PHY addr, [22:18] reg addr, [17:16] TA, [15:0] write data.
- GNT_A  output  1  A owns the controller.
- DONE_A  output  1  one-cycle completion pulse to A.
- RD_DATA_A  output  16  read result for A.
- REQ_B, T_DATA_B, GNT_B, DONE_B, RD_DATA_B  same as A, for requester B.
- MDIO_START  output  1  one-cycle launch pulse to the controller.
- T_DATA  output  32  frame to the controller, stable from START through WAIT.
- DATA_RDY  input  1  controller completion pulse.
- RD_DATA  input  16  controller read data, valid with DATA_RDY.
- BUSY  output  1  high in any state except IDLE.
- ERR  output  1  one-cycle pulse, coincident with DONE_x, on timeout or invalid OP.

Behaviour:
- Reset (sync, high): state = IDLE. All outputs 0, RD_DATA_A/B = 16'h0000, counter = 0, last_served = B (so A wins the first tie). Reset asserted in any state aborts immediately; no DONE is issued.
- Four-state FSM:
  - IDLE: if REQ_A or REQ_B is sampled, select an owner and latch that owner's T_DATA into frame_q. Go to START if OP ∈ {01 write, 10 read}; else go to DONE with err flag set.
  - START: one cycle; MDIO_START = 1, T_DATA = frame_q, GNT_owner = 1; go to WAIT and clear the counter.
  - WAIT: GNT_owner = 1, T_DATA = frame_q. On DATA_RDY go to DONE and capture RD_DATA if OP = 10. Otherwise increment the counter; when counter reaches TIMEOUT-1 with no DATA_RDY, go to DONE with err flag set.
  - DONE: one cycle.
    - DONE_owner = 1, GNT_owner = 1, ERR = err flag.
    - RD_DATA_owner is updated on a successful read, or forced to 16'hFFFF on a read that hit timeout or had an invalid OP.
    - Writes leave RD_DATA_owner unchanged.
    - last_served = owner; go to IDLE.
- Arbitration: with a single request, grant it. With simultaneous requests, grant the requester not equal to last_served.
- Latency: REQ sampled at edge k → MDIO_START and GNT high in cycle k+1. Minimum turnaround is DONE → IDLE → START, so back-to-back transactions are separated by 1 idle cycle.
- DATA_RDY during IDLE, START or DONE is ignored.
- REQ dropped mid-transaction does not abort; the transaction completes and DONE is still pulsed.
- The non-owner's REQ is ignored until IDLE.
- GNT_A and GNT_B are never high together. MDIO_START is never high outside START.
- T_DATA = 32'h0 in IDLE.
- Frame bits other than OP are passed through unchecked.

Test Plan:
- Write from A: REQ_A=1, T_DATA_A=32'h5152_5555, DATA_RDY after 32 cycles → one MDIO_START pulse, T_DATA=32'h51525555, DONE_A pulse, ERR=0, RD_DATA_A stays 16'h0000.
- Read from B: REQ_B=1, T_DATA_B=32'h6152_0000, DATA_RDY with RD_DATA=16'hAAAA → DONE_B pulse, RD_DATA_B=16'hAAAA, GNT_A never high.
- Fairness: REQ_A and REQ_B high together for 3 transactions → grant order A, B, A; 1 idle cycle between DONE and the next MDIO_START; GNTs never overlap.
- Timeout: REQ_A read, DATA_RDY never asserted → DONE_A and ERR pulse exactly TIMEOUT cycles after entering WAIT, RD_DATA_A=16'hFFFF; a late DATA_RDY is ignored.
- Invalid OP: T_DATA_B OP=2'b11 → no MDIO_START, DONE_B and ERR pulse 1 cycle after IDLE sample, RD_DATA_B=16'hFFFF.
- Reset mid-WAIT: reset=1 for 1 cycle during WAIT → next cycle IDLE, all outputs 0, no DONE. A pending REQ_A and REQ_B then resolves to A.

Source files
------------

// File: rtl/mdio_arbitro.sv
// Round-robin arbiter/sequencer that lets two host requesters share one MDIO
// management controller, with per-transaction timeout and invalid-OP rejection.
module mdio_arbitro #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        MDC,
  input  logic        reset,
  input  logic        REQ_A,
  input  logic [31:0] T_DATA_A,
  output logic        GNT_A,
  output logic        DONE_A,
  output logic [15:0] RD_DATA_A,
  input  logic        REQ_B,
  input  logic [31:0] T_DATA_B,
  output logic        GNT_B,
  output logic        DONE_B,
  output logic [15:0] RD_DATA_B,
  output logic        MDIO_START,
  output logic [31:0] T_DATA,
  input  logic        DATA_RDY,
  input  logic [15:0] RD_DATA,
  output logic        BUSY,
  output logic        ERR
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  localparam logic [1:0]       OP_WR   = 2'b01;
  localparam logic [1:0]       OP_RD   = 2'b10;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TIMEOUT - 1);

  state_t      state;
  logic        owner;        // 0 = A, 1 = B
  logic        last_served;  // 0 = A, 1 = B
  logic [31:0] frame_q;
  logic [CNT_W-1:0] cnt;

  logic        pick_b;
  logic [31:0] pick_frame;
  logic        pick_ok;
  logic        is_read;

  // On a tie, B wins only if A was the last one served.
  always_comb begin
    pick_b     = REQ_B && (!REQ_A || !last_served);
    pick_frame = pick_b ? T_DATA_B : T_DATA_A;
    pick_ok    = (pick_frame[29:28] == OP_WR) || (pick_frame[29:28] == OP_RD);
    is_read    = (frame_q[29:28] == OP_RD);
  end

  always_ff @(posedge MDC) begin
    if (reset) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      frame_q     <= 32'h0;
      cnt         <= '0;
      GNT_A       <= 1'b0;
      GNT_B       <= 1'b0;
      DONE_A      <= 1'b0;
      DONE_B      <= 1'b0;
      RD_DATA_A   <= 16'h0000;
      RD_DATA_B   <= 16'h0000;
      MDIO_START  <= 1'b0;
      T_DATA      <= 32'h0;
      BUSY        <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (REQ_A || REQ_B) begin
            owner   <= pick_b;
            frame_q <= pick_frame;
            GNT_A   <= !pick_b;
            GNT_B   <= pick_b;
            BUSY    <= 1'b1;
            if (pick_ok) begin
              state      <= S_START;
              MDIO_START <= 1'b1;
              T_DATA     <= pick_frame;
            end else begin
              // Bad OP never reaches the controller; report it straight away.
              state  <= S_DONE;
              DONE_A <= !pick_b;
              DONE_B <= pick_b;
              ERR    <= 1'b1;
              if (pick_b) RD_DATA_B <= 16'hFFFF;
              else        RD_DATA_A <= 16'hFFFF;
            end
          end
        end
        S_START: begin
          MDIO_START <= 1'b0;
          cnt        <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (DATA_RDY) begin
            state  <= S_DONE;
            DONE_A <= !owner;
            DONE_B <= owner;
            if (is_read) begin
              if (owner) RD_DATA_B <= RD_DATA;
              else       RD_DATA_A <= RD_DATA;
            end
          end else if (cnt == CNT_END) begin
            state  <= S_DONE;
            DONE_A <= !owner;
            DONE_B <= owner;
            ERR    <= 1'b1;
            if (is_read) begin
              if (owner) RD_DATA_B <= 16'hFFFF;
              else       RD_DATA_A <= 16'hFFFF;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state       <= S_IDLE;
          last_served <= owner;
          GNT_A       <= 1'b0;
          GNT_B       <= 1'b0;
          DONE_A      <= 1'b0;
          DONE_B      <= 1'b0;
          ERR         <= 1'b0;
          BUSY        <= 1'b0;
          T_DATA      <= 32'h0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_arbitro.sv
// Directed bench for mdio_arbitro: scoreboard of expected completions plus
// per-cycle protocol checks (grant exclusivity, START/DONE/ERR framing).
module tb_mdio_arbitro;

  localparam int TIMEOUT = 64;

  logic        MDC = 1'b0;
  logic        reset;
  logic        REQ_A, REQ_B, DATA_RDY;
  logic [31:0] T_DATA_A, T_DATA_B;
  logic [15:0] RD_DATA;
  logic        GNT_A, DONE_A, GNT_B, DONE_B, MDIO_START, BUSY, ERR;
  logic [15:0] RD_DATA_A, RD_DATA_B;
  logic [31:0] T_DATA;

  mdio_arbitro #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .MDC(MDC), .reset(reset),
    .REQ_A(REQ_A), .T_DATA_A(T_DATA_A), .GNT_A(GNT_A), .DONE_A(DONE_A), .RD_DATA_A(RD_DATA_A),
    .REQ_B(REQ_B), .T_DATA_B(T_DATA_B), .GNT_B(GNT_B), .DONE_B(DONE_B), .RD_DATA_B(RD_DATA_B),
    .MDIO_START(MDIO_START), .T_DATA(T_DATA), .DATA_RDY(DATA_RDY), .RD_DATA(RD_DATA),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 MDC = ~MDC;

  typedef struct packed {
    logic        owner;
    logic [15:0] rd;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0, passed = 0, fails = 0;
  int cyc_n = 0, start_cnt = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0;
  logic [31:0] start_frame = 32'h0;
  logic        start_b = 1'b0;
  logic        gnt_a_seen = 1'b0;
  logic [15:0] mdl_rd_a = 16'h0, mdl_rd_b = 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: sample at the falling edge and run the per-cycle checks.
  task automatic cyc();
    exp_t e;
    @(negedge MDC);
    cyc_n++;
    chk("gnt_excl", {31'b0, GNT_A & GNT_B}, 0);
    chk("err_without_done", {31'b0, ERR & ~(DONE_A | DONE_B)}, 0);
    if (GNT_A) gnt_a_seen = 1'b1;
    if (!BUSY) chk("idle_quiet", {T_DATA[31:1], T_DATA[0] | GNT_A | GNT_B | MDIO_START}, 0);
    if (MDIO_START) begin
      start_cnt++;
      start_cyc   = cyc_n;
      start_frame = T_DATA;
      start_b     = GNT_B;
      chk("start_has_gnt", {31'b0, GNT_A | GNT_B}, 1);
    end
    if (DONE_A || DONE_B) begin
      done_cnt++;
      done_cyc = cyc_n;
      chk("done_excl", {31'b0, DONE_A & DONE_B}, 0);
      chk("done_has_gnt", {30'b0, GNT_A, GNT_B}, {30'b0, DONE_A, DONE_B});
      chk("sb_nonempty", {31'b0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("done_owner", {31'b0, DONE_B}, {31'b0, e.owner});
        chk("done_err", {31'b0, ERR}, {31'b0, e.err});
        chk("rd_data", {16'b0, (e.owner ? RD_DATA_B : RD_DATA_A)}, {16'b0, e.rd});
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin cyc(); n++; end
    chk("done_seen", {31'b0, done_cnt != d0}, 1);
  endtask

  task automatic wait_start(input int budget);
    int s0 = start_cnt;
    int n = 0;
    while (start_cnt == s0 && n < budget) begin cyc(); n++; end
    chk("start_seen", {31'b0, start_cnt != s0}, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {GNT_A, GNT_B, DONE_A, DONE_B, MDIO_START, BUSY, ERR, 25'b0}, 0);
    chk({tag, "_tdata"}, T_DATA, 0);
    chk({tag, "_rd"}, {RD_DATA_A, RD_DATA_B}, 0);
  endtask

  logic [31:0] fr_a, fr_b;
  int req_cyc, s0, d0;

  initial begin
    reset = 1'b1; REQ_A = 0; REQ_B = 0; DATA_RDY = 0;
    T_DATA_A = 0; T_DATA_B = 0; RD_DATA = 0;
    repeat (3) cyc();
    chk_all_zero("reset_state");
    reset = 1'b0;
    cyc();
    chk_all_zero("post_reset_idle");

    // Write from A
    exp_q.push_back('{owner: 1'b0, rd: mdl_rd_a, err: 1'b0});
    s0 = start_cnt;
    T_DATA_A = 32'h5152_5555; REQ_A = 1;
    cyc();
    chk("wr_start_latency", {31'b0, MDIO_START}, 1);
    chk("wr_start_frame", start_frame, 32'h5152_5555);
    chk("wr_start_gnt_a", {31'b0, start_b}, 0);
    repeat (10) cyc();
    chk("wr_tdata_wait", T_DATA, 32'h5152_5555);
    chk("wr_busy", {31'b0, BUSY}, 1);
    repeat (21) cyc();
    DATA_RDY = 1;
    wait_done(4);
    DATA_RDY = 0; REQ_A = 0;
    chk("wr_one_start", start_cnt - s0, 1);
    cyc();
    chk("wr_rd_a_kept", {16'b0, RD_DATA_A}, 32'h0);

    // Read from B
    gnt_a_seen = 0;
    mdl_rd_b = 16'hAAAA;
    exp_q.push_back('{owner: 1'b1, rd: mdl_rd_b, err: 1'b0});
    T_DATA_B = 32'h6152_0000; REQ_B = 1;
    wait_start(3);
    chk("rd_start_gnt_b", {31'b0, start_b}, 1);
    chk("rd_start_frame", start_frame, 32'h6152_0000);
    repeat (5) cyc();
    RD_DATA = 16'hAAAA; DATA_RDY = 1;
    wait_done(4);
    DATA_RDY = 0; REQ_B = 0; RD_DATA = 0;
    cyc();
    chk("rd_gnt_a_never", {31'b0, gnt_a_seen}, 0);
    chk("rd_b_held", {16'b0, RD_DATA_B}, 32'h0000_AAAA);

    // Fairness: both requesting for three rounds -> A, B, A
    fr_a = 32'h5123_4567; fr_b = 32'h6ABC_0000;
    T_DATA_A = fr_a; T_DATA_B = fr_b; REQ_A = 1; REQ_B = 1;
    for (int r = 0; r < 3; r++) begin
      if (r == 1) begin
        mdl_rd_b = 16'h1111;
        exp_q.push_back('{owner: 1'b1, rd: mdl_rd_b, err: 1'b0});
      end else begin
        exp_q.push_back('{owner: 1'b0, rd: mdl_rd_a, err: 1'b0});
      end
      wait_start(4);
      chk("fair_owner", {31'b0, start_b}, (r == 1) ? 1 : 0);
      chk("fair_frame", start_frame, (r == 1) ? fr_b : fr_a);
      if (r > 0) chk("fair_gap", start_cyc - done_cyc, 2);
      repeat (3) cyc();
      RD_DATA = 16'h1111; DATA_RDY = 1;
      wait_done(4);
      DATA_RDY = 0; RD_DATA = 0;
    end
    REQ_A = 0; REQ_B = 0;
    cyc();

    // Invalid OP from B: no launch, immediate error completion
    mdl_rd_b = 16'hFFFF;
    exp_q.push_back('{owner: 1'b1, rd: mdl_rd_b, err: 1'b1});
    s0 = start_cnt;
    T_DATA_B = 32'h7152_0000; REQ_B = 1;
    req_cyc = cyc_n;
    wait_done(4);
    REQ_B = 0;
    chk("inv_latency", done_cyc - req_cyc, 1);
    cyc();
    chk("inv_no_start", start_cnt - s0, 0);

    // Timeout on an A read; late DATA_RDY afterwards is ignored
    mdl_rd_a = 16'hFFFF;
    exp_q.push_back('{owner: 1'b0, rd: mdl_rd_a, err: 1'b1});
    T_DATA_A = 32'h6000_0000; REQ_A = 1;
    wait_start(3);
    wait_done(TIMEOUT + 8);
    REQ_A = 0;
    chk("to_latency", done_cyc - start_cyc, TIMEOUT + 1);
    d0 = done_cnt;
    cyc();
    RD_DATA = 16'h1234; DATA_RDY = 1;
    cyc();
    DATA_RDY = 0; RD_DATA = 0;
    repeat (2) cyc();
    chk("to_late_rdy_done", done_cnt - d0, 0);
    chk("to_rd_a_kept", {16'b0, RD_DATA_A}, 32'h0000_FFFF);
    chk("to_idle", {31'b0, BUSY}, 0);

    // Reset in WAIT, then both pending -> A wins
    T_DATA_A = 32'h5000_0001; REQ_A = 1;
    wait_start(3);
    repeat (3) cyc();
    d0 = done_cnt;
    T_DATA_B = 32'h5000_0002; REQ_B = 1;
    reset = 1;
    cyc();
    chk_all_zero("rst_wait");
    reset = 0;
    mdl_rd_a = 16'h0; mdl_rd_b = 16'h0;
    exp_q.push_back('{owner: 1'b0, rd: mdl_rd_a, err: 1'b0});
    wait_start(3);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_owner_a", {31'b0, start_b}, 0);
    chk("rst_frame", start_frame, 32'h5000_0001);
    repeat (2) cyc();
    DATA_RDY = 1;
    wait_done(4);
    DATA_RDY = 0; REQ_A = 0; REQ_B = 0;
    repeat (2) cyc();
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
